// File: rtl/match_result_collector_if.sv
// Packet/stream bundle for match_result_collector.
// Carries match_cnt only when MRC_MATCH_COUNT_EN is defined.
interface match_result_collector_if #(
    parameter int VECTOR_SIZE = 98,
    parameter int ID_WIDTH    = 10,
    parameter int FLOW_WIDTH  = 7
);
    localparam int CNT_WIDTH = $clog2(VECTOR_SIZE + 1);

    logic                   sop;
    logic                   eop;
    logic [FLOW_WIDTH-1:0]  flow_in;
    logic [VECTOR_SIZE-1:0] match_vec;
    logic                   ready;
    logic                   out_vld;
    logic                   out_rdy;
    logic [ID_WIDTH-1:0]    out_id;
    logic [FLOW_WIDTH-1:0]  out_flow;
    logic                   out_last;
    logic                   proto_err;
`ifdef MRC_MATCH_COUNT_EN
    logic [CNT_WIDTH-1:0]   match_cnt;

    modport master (
        output sop, eop, flow_in, match_vec, out_rdy,
        input  ready, out_vld, out_id, out_flow, out_last,
        input  proto_err, match_cnt
    );
    modport slave (
        input  sop, eop, flow_in, match_vec, out_rdy,
        output ready, out_vld, out_id, out_flow, out_last,
        output proto_err, match_cnt
    );
`else
    modport master (
        output sop, eop, flow_in, match_vec, out_rdy,
        input  ready, out_vld, out_id, out_flow, out_last,
        input  proto_err
    );
    modport slave (
        input  sop, eop, flow_in, match_vec, out_rdy,
        output ready, out_vld, out_id, out_flow, out_last,
        output proto_err
    );
`endif
endinterface

// File: rtl/match_result_collector.sv
// Per-packet match-ID collector: snapshots match_vec after eop and streams set bits.
// MRC_MATCH_COUNT_EN adds match_cnt and a sentinel record for empty packets.
module match_result_collector #(
    parameter int VECTOR_SIZE = 98,
    parameter int ID_WIDTH    = 10,
    parameter int ID_BASE     = 0,
    parameter int FLOW_WIDTH  = 7,
    parameter int EOP_DELAY   = 10
) (
    input logic                      clk,
    input logic                      rst_n,
    match_result_collector_if.slave  bus
);
    localparam int CW = $clog2(EOP_DELAY) + 1;
    localparam int IW = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;

    typedef enum logic [1:0] {IDLE, PKT, WAIT, SCAN} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [FLOW_WIDTH-1:0]  flow;
    logic [VECTOR_SIZE-1:0] shadow;

    logic [VECTOR_SIZE-1:0] enc_src;
    logic [VECTOR_SIZE-1:0] enc_rest;
    logic [IW-1:0]          enc_idx;
    logic                   enc_hit;
    logic [ID_WIDTH-1:0]    enc_id;

    // Snapshot cycle encodes the live vector so the first ID lands with SCAN entry.
    always_comb begin
        enc_src  = (state == WAIT) ? bus.match_vec : shadow;
        enc_rest = enc_src & (enc_src - VECTOR_SIZE'(1));
        enc_hit  = |enc_src;
        enc_idx  = '0;
        for (int i = VECTOR_SIZE - 1; i >= 0; i--) begin
            if (enc_src[i]) enc_idx = IW'(i);
        end
        enc_id = ID_WIDTH'(ID_BASE) + ID_WIDTH'(enc_idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            flow          <= '0;
            shadow        <= '0;
            bus.ready     <= 1'b1;
            bus.out_vld   <= 1'b0;
            bus.out_id    <= '0;
            bus.out_flow  <= '0;
            bus.out_last  <= 1'b0;
            bus.proto_err <= 1'b0;
`ifdef MRC_MATCH_COUNT_EN
            bus.match_cnt <= '0;
`endif
        end else begin
            if (bus.sop && (state == WAIT || state == SCAN))
                bus.proto_err <= 1'b1;
            if (bus.eop && (state == WAIT || state == SCAN))
                bus.proto_err <= 1'b1;
            unique case (state)
                IDLE, PKT: begin
                    if (bus.sop) flow <= bus.flow_in;
                    if (bus.eop) begin
                        state     <= WAIT;
                        bus.ready <= 1'b0;
                        cnt       <= CW'(EOP_DELAY - 1);
                    end else if (bus.sop) begin
                        state <= PKT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state    <= SCAN;
                        shadow   <= enc_rest;
`ifdef MRC_MATCH_COUNT_EN
                        bus.match_cnt <= $bits(bus.match_cnt)'(
                            $countones(bus.match_vec));
`endif
                        bus.out_flow <= flow;
                        if (enc_hit) begin
                            bus.out_vld  <= 1'b1;
                            bus.out_id   <= enc_id;
                            bus.out_last <= ~|enc_rest;
                        end else begin
`ifdef MRC_MATCH_COUNT_EN
                            bus.out_vld  <= 1'b1;
                            bus.out_id   <= '1;
                            bus.out_last <= 1'b1;
`else
                            bus.out_vld  <= 1'b0;
`endif
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                SCAN: begin
                    if (!bus.out_vld) begin
                        state     <= IDLE;
                        bus.ready <= 1'b1;
                    end else if (bus.out_rdy) begin
                        if (bus.out_last) begin
                            state        <= IDLE;
                            bus.ready    <= 1'b1;
                            bus.out_vld  <= 1'b0;
                            bus.out_last <= 1'b0;
                        end else begin
                            bus.out_id   <= enc_id;
                            bus.out_last <= ~|enc_rest;
                            shadow       <= enc_rest;
                        end
                    end
                end
            endcase
        end
    end
endmodule
